// File: rtl/operand_fifo_reg.sv
// operand_fifo_reg: small in-order operand buffer between the register file
// read phase (p3 capture strobe) and one ALU operand input.
// It lets register reads run ahead while the ALU stalls.
// Optional build macro OPERAND_FIFO_OVFL_FLAG_EN adds a sticky "overflow"
// output that records a capture dropped because the buffer was full.
module operand_fifo_reg #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             p3,
  input  logic [WIDTH-1:0] data_from_regfile,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_to_ALU,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
`ifdef OPERAND_FIFO_OVFL_FLAG_EN
  ,
  output logic             overflow
`endif
);

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             push, pop;

  // Handshake status and head word, all derived from registered state only.
  always_comb begin
    in_ready    = (count != CNT_W'(DEPTH));
    out_valid   = (count != '0);
    push        = p3 && in_ready;
    pop         = out_valid && out_ready;
    data_to_ALU = out_valid ? mem[rd_ptr] : '0;
  end

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since out_valid masks the head.
  always_ff @(posedge clock) begin
    if (push && !reset && !flush) mem[wr_ptr] <= data_from_regfile;
  end

`ifdef OPERAND_FIFO_OVFL_FLAG_EN
  // Sticky record of a capture attempted while full; clearing wins over set.
  always_ff @(posedge clock) begin
    if (reset || flush)      overflow <= 1'b0;
    else if (p3 && !in_ready) overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_operand_fifo_reg.sv
// Directed bench for operand_fifo_reg (WIDTH=16, DEPTH=4).
module tb_operand_fifo_reg;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset, flush, p3, out_ready;
  logic [WIDTH-1:0] data_from_regfile;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] data_to_ALU;
  logic [CNT_W-1:0] count;
`ifdef OPERAND_FIFO_OVFL_FLAG_EN
  logic             overflow;
`endif

  int total = 0;
  int bad   = 0;

  operand_fifo_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock             (clock),
    .reset             (reset),
    .flush             (flush),
    .p3                (p3),
    .data_from_regfile (data_from_regfile),
    .in_ready          (in_ready),
    .data_to_ALU       (data_to_ALU),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .count             (count)
`ifdef OPERAND_FIFO_OVFL_FLAG_EN
    ,
    .overflow          (overflow)
`endif
  );

  always #5 clock = ~clock;

  // Advance one edge and settle 1 time unit past it before checking.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push1(input logic [WIDTH-1:0] d);
    p3 = 1'b1; data_from_regfile = d;
    tick();
    p3 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; p3 = 1'b1; out_ready = 1'b0;
    data_from_regfile = 16'hFFFF;

    // Reset held two cycles with p3 high
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_data", 32'(data_to_ALU), 32'h0000);
    reset = 1'b0; p3 = 1'b0;
    tick();
    chk("idle_count", 32'(count), 32'd0);

    // Single pass; no combinational path before the edge
    p3 = 1'b1; data_from_regfile = 16'h1234;
    #1;
    chk("no_comb_path", 32'(out_valid), 32'd0);
    tick(); p3 = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(data_to_ALU), 32'h1234);
    chk("single_count", 32'(count), 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("single_pop_count", 32'(count), 32'd0);
    chk("single_pop_valid", 32'(out_valid), 32'd0);

    // Pop on empty is ignored
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("empty_pop_count", 32'(count), 32'd0);
    chk("empty_pop_data", 32'(data_to_ALU), 32'h0000);

    // Fill to DEPTH, then a dropped capture
    push1(16'hA001); push1(16'hA002); push1(16'hA003); push1(16'hA004);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    push1(16'hA005);
    chk("drop_count", 32'(count), 32'd4);
`ifdef OPERAND_FIFO_OVFL_FLAG_EN
    chk("drop_overflow", 32'(overflow), 32'd1);
`endif

    // Drain in order
    out_ready = 1'b1;
    chk("drain0", 32'(data_to_ALU), 32'hA001); tick();
    chk("drain1", 32'(data_to_ALU), 32'hA002); tick();
    chk("drain2", 32'(data_to_ALU), 32'hA003); tick();
    chk("drain3", 32'(data_to_ALU), 32'hA004); tick();
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // Full with simultaneous pop: capture still dropped, slot shows next cycle
    push1(16'hE001); push1(16'hE002); push1(16'hE003); push1(16'hE004);
    p3 = 1'b1; out_ready = 1'b1; data_from_regfile = 16'hE005;
    tick(); p3 = 1'b0; out_ready = 1'b0;
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_in_ready", 32'(in_ready), 32'd1);
    chk("fullpop_head", 32'(data_to_ALU), 32'hE002);
    out_ready = 1'b1; tick(); tick(); tick(); out_ready = 1'b0;
    chk("fullpop_empty", 32'(count), 32'd0);

    // Simultaneous push/pop across pointer wrap with count=2
    push1(16'hC000); push1(16'hC001);
    p3 = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_from_regfile = 16'h0B00 + 16'(i);
      chk($sformatf("pp_head%0d", i), 32'(data_to_ALU),
          (i < 2) ? 32'hC000 + 32'(i) : 32'h0B00 + 32'(i - 2));
      tick();
      chk($sformatf("pp_count%0d", i), 32'(count), 32'd2);
    end
    p3 = 1'b0; out_ready = 1'b0;
    chk("pp_final_head", 32'(data_to_ALU), 32'h0B04);

    // Flush with count=3 and same-cycle push/pop
    push1(16'hD000);
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1; p3 = 1'b1; out_ready = 1'b1; data_from_regfile = 16'h7777;
    tick();
    flush = 1'b0; p3 = 1'b0; out_ready = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
`ifdef OPERAND_FIFO_OVFL_FLAG_EN
    chk("flush_overflow", 32'(overflow), 32'd0);
`endif
    push1(16'h5555);
    chk("post_flush_head", 32'(data_to_ALU), 32'h5555);
    chk("post_flush_count", 32'(count), 32'd1);

    // Reset mid-operation from full (with overflow set)
    push1(16'h6001); push1(16'h6002); push1(16'h6003);
    push1(16'h6004);
    chk("prereset_count", 32'(count), 32'd4);
    chk("prereset_head", 32'(data_to_ALU), 32'h5555);
`ifdef OPERAND_FIFO_OVFL_FLAG_EN
    chk("prereset_overflow", 32'(overflow), 32'd1);
`endif
    reset = 1'b1; p3 = 1'b1; out_ready = 1'b1; data_from_regfile = 16'h9999;
    tick();
    reset = 1'b0; p3 = 1'b0; out_ready = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(data_to_ALU), 32'h0000);
`ifdef OPERAND_FIFO_OVFL_FLAG_EN
    chk("midrst_overflow", 32'(overflow), 32'd0);
`endif
    tick();
    chk("midrst_nocapture", 32'(count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fifo_reg.md
Name: operand_fifo_reg

Overview:
Parametrised successor to the single ALU operand register. Buffers up to DEPTH operand words captured from the register file on the p3 phase strobe and presents them in order to the ALU with a valid/ready handshake. This lets the register-file read phase run ahead of the ALU when the ALU stalls. One instance is used per ALU operand (A or B). A flush input discards queued operands on a pipeline redirect.

Parameters:
WIDTH, 16, operand width in bits
DEPTH, 4, number of buffered entries; power of 2, minimum 2
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden)

Ports:
clock  input  1  single clock; all state updates on the posedge
reset  input  1  synchronous, active-high; clears all state on a clock edge where it is high
flush  input  1  synchronous discard of all buffered entries
p3  input  1  capture strobe; a write is requested while this is high
data_from_regfile  input  WIDTH  operand word written on an accepted capture
in_ready  output  1  buffer can accept a capture this cycle
data_to_ALU  output  WIDTH  oldest buffered operand (head)
out_valid  output  1  data_to_ALU holds a valid operand
out_ready  input  1  ALU consumes the head this cycle
count  output  CNT_W  number of occupied entries, 0..DEPTH
overflow  output  1  sticky dropped-capture flag; present only with OVFL_FLAG_EN

Behaviour:
- Storage: DEPTH x WIDTH array, read pointer, write pointer and count register. Pointers wrap modulo DEPTH.
- Reset (highest priority): rd_ptr=0, wr_ptr=0, count=0, overflow=0. Array contents are don't-care. Outputs during and after reset: in_ready=1, out_valid=0, data_to_ALU=0, count=0.
- Reset in the middle of operation discards all entries on that edge; no push or pop takes effect on that edge.
- Derived signals:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - data_to_ALU = mem[rd_ptr] when out_valid, else all-zero. It is combinational from the registered state, so it changes only after a clock edge.
- Push: p3 && in_ready. Writes data_from_regfile to mem[wr_ptr]; wr_ptr+1.
- Pop: out_valid && out_ready. rd_ptr+1.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - neither: unchanged.
- Latency: a word pushed into an empty buffer appears on data_to_ALU with out_valid=1 one cycle later. There is no combinational input-to-output path.
- Full: in_ready=0 and p3 is ignored (word dropped), even if a pop occurs the same cycle. The slot freed by that pop becomes visible as in_ready=1 on the next cycle.
- Empty: out_ready is ignored; no pointer change, no underflow.
- Flush (priority below reset, above push/pop): rd_ptr=0, wr_ptr=0, count=0. A push or pop in the same cycle is discarded. The next cycle shows out_valid=0 and in_ready=1.
- Ordering: strict FIFO; no reordering, no duplication.

Optional Feature:
Macro OPERAND_FIFO_OVFL_FLAG_EN.
- Defined:
  - overflow port exists.
  - Set to 1 on any edge where p3=1 and in_ready=0.
  - Holds until reset or flush; clearing by reset or flush wins over a same-cycle set.
- Not defined:
  - overflow port and its logic are absent.
  - Dropped captures when full are silent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold reset=1 for 2 cycles with p3=1 -> count=0, out_valid=0, in_ready=1, data_to_ALU=16'h0000.
- Single pass: pulse p3 with data 16'h1234, out_ready=0 -> next cycle out_valid=1, data_to_ALU=16'h1234, count=1. Then assert out_ready for 1 cycle -> count=0, out_valid=0.
- Fill and drain (DEPTH=4): push 16'hA001..16'hA004 on consecutive cycles, out_ready=0 -> in_ready=0, count=4. A 5th push of 16'hA005 is dropped (overflow=1 if OVFL_FLAG_EN). Draining yields A001, A002, A003, A004 in order, then out_valid=0.
- Simultaneous push/pop with wrap: with count=2, hold p3=1 and out_ready=1 for 6 cycles using data 16'h0B00+i -> count stays 2 and outputs stay in order across pointer wrap.
- Flush: with count=3, assert flush together with p3=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, overflow cleared. A subsequent push of 16'h5555 appears alone at the head.
- Reset mid-operation: with count=4 and overflow=1, assert reset for 1 cycle together with p3=1 -> count=0, overflow=0, out_valid=0; nothing captured.
